secuenciador_adc: RTL and testbench

Sequencer and SPI bus owner for the analog capture chain: programmable preamp (8-bit gain register) plus dual-channel 14-bit ADC sharing SPI_SCK. After reset it loads a default gain into the preamp, then schedules ADC frames at a fixed sample rate and delivers both channels with a one-cycle `ready` pulse. It arbitrates the shared bus between gain rewrites requested by the host logic and periodic conversions. It replaces free-running, clock-gated conversion logic.

---
 rtl/adc_pkg.sv | 30 +++
 rtl/generador_sck.sv | 48 ++++
 rtl/secuenciador_adc.sv | 219 +++++++++++++++++++++
 tb/tb_secuenciador_adc.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and frame geometry for the ADC capture sequencer.
package adc_pkg;

  typedef enum logic [2:0] {
    INIT_WR,
    AMP_CS,
    AMP_SHIFT,
    AMP_END,
    IDLE,
    CONV,
    ADC_SHIFT,
    DONE
  } state_t;

  localparam int unsigned ADC_FRAME_BITS = 34;
  localparam int unsigned CH_BITS        = 14;
  localparam int unsigned AMP_BITS       = 8;

  // SCK periods (1-based) that carry channel data, MSB first
  localparam int unsigned CH_A_FIRST = 3;
  localparam int unsigned CH_A_LAST  = 16;
  localparam int unsigned CH_B_FIRST = 19;
  localparam int unsigned CH_B_LAST  = 32;

  function automatic logic in_win(input logic [5:0] p, input int unsigned lo,
                                  input int unsigned hi);
    return (32'(p) >= lo) && (32'(p) <= hi);
  endfunction

endpackage

// File: rtl/generador_sck.sv
// Register-based SPI clock divider; SCK idles low and restarts cleanly on each enable.
module generador_sck #(
  parameter int unsigned SCK_HALF = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic sck_o,
  output logic rise_tick_o,
  output logic fall_tick_o
);

  localparam int unsigned CW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic          wrap;

  assign wrap        = en_i && (cnt_q == CW'(SCK_HALF - 1));
  assign rise_tick_o = wrap && !sck_q;
  assign fall_tick_o = wrap && sck_q;
  assign sck_o       = sck_q;

  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!en_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (wrap) begin
      cnt_d = '0;
      sck_d = !sck_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/secuenciador_adc.sv
// Owns the shared SPI bus: preamp gain writes (reset default and host requests)
// interleaved with periodic dual-channel ADC frames.
module secuenciador_adc
  import adc_pkg::*;
#(
  parameter int unsigned SCK_HALF   = 3,
  parameter int unsigned SAMPLE_DIV = 1000,
  parameter logic [7:0]  GAIN_RESET = 8'h11
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [AMP_BITS-1:0] gain_in,
  input  logic                gain_wr,
  output logic                gain_busy,
  output logic [CH_BITS-1:0]  datos_a,
  output logic [CH_BITS-1:0]  datos_b,
  output logic                ready,
  output logic                overrun,
  output logic                spi_sck,
  output logic                spi_mosi,
  input  logic                spi_miso,
  output logic                amp_cs,
  output logic                amp_shdn,
  output logic                ad_conv
);

  localparam int unsigned CW = $clog2(2 * SCK_HALF);
  localparam int unsigned TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [5:0]          bits_q, bits_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic [AMP_BITS-1:0] amp_sr_q, amp_sr_d, gain_q, gain_d;
  logic                gain_pend_q, gain_pend_d, busy_q, busy_d;
  logic                frame_pend_q, frame_pend_d, overrun_q, overrun_d;
  logic [CH_BITS-1:0]  sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  logic [CH_BITS-1:0]  datos_a_q, datos_a_d, datos_b_q, datos_b_d;
  logic                ready_q, ready_d, amp_cs_q, amp_cs_d, ad_conv_q, ad_conv_d;

  logic       sck_en, rise_tick, fall_tick, tick, frame_active;
  logic [5:0] period;

  assign sck_en       = (state_q == AMP_SHIFT) || (state_q == ADC_SHIFT);
  assign tick         = (tick_q == TW'(SAMPLE_DIV - 1));
  assign frame_active = (state_q == CONV) || (state_q == ADC_SHIFT) || (state_q == DONE);
  assign period       = bits_q + 6'd1;

  generador_sck #(.SCK_HALF(SCK_HALF)) u_sck (
    .clk_i      (clock),
    .rst_ni     (reset_n),
    .en_i       (sck_en),
    .sck_o      (spi_sck),
    .rise_tick_o(rise_tick),
    .fall_tick_o(fall_tick)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bits_d       = bits_q;
    amp_sr_d     = amp_sr_q;
    gain_d       = gain_q;
    gain_pend_d  = gain_pend_q;
    busy_d       = busy_q;
    frame_pend_d = frame_pend_q;
    overrun_d    = overrun_q;
    sh_a_d       = sh_a_q;
    sh_b_d       = sh_b_q;
    datos_a_d    = datos_a_q;
    datos_b_d    = datos_b_q;
    ready_d      = 1'b0;
    amp_cs_d     = amp_cs_q;
    ad_conv_d    = ad_conv_q;
    tick_d       = tick ? '0 : tick_q + 1'b1;

    if (tick && enable) begin
      if (frame_pend_q || frame_active) overrun_d = 1'b1;
      else                              frame_pend_d = 1'b1;
    end
    if (gain_wr && !busy_q) begin
      gain_d      = gain_in;
      gain_pend_d = 1'b1;
      busy_d      = 1'b1;
    end

    // The case below runs after the request latching so bus consumption wins.
    case (state_q)
      INIT_WR: begin
        amp_sr_d    = GAIN_RESET;
        gain_pend_d = 1'b0;
        busy_d      = 1'b1;
        amp_cs_d    = 1'b0;
        cnt_d       = '0;
        state_d     = AMP_CS;
      end
      AMP_CS: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(SCK_HALF - 1)) begin
          cnt_d   = '0;
          state_d = AMP_SHIFT;
        end
      end
      AMP_SHIFT: begin
        if (fall_tick) begin
          amp_sr_d = {amp_sr_q[AMP_BITS-2:0], 1'b0};
          bits_d   = bits_q + 6'd1;
          if (bits_q == 6'(AMP_BITS - 1)) begin
            bits_d  = '0;
            state_d = AMP_END;
          end
        end
      end
      AMP_END: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(SCK_HALF - 1)) begin
          cnt_d    = '0;
          amp_cs_d = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      IDLE: begin
        if (gain_pend_q) begin
          gain_pend_d = 1'b0;
          amp_sr_d    = gain_q;
          amp_cs_d    = 1'b0;
          cnt_d       = '0;
          state_d     = AMP_CS;
        end else if (frame_pend_q) begin
          frame_pend_d = 1'b0;
          ad_conv_d    = 1'b1;
          cnt_d        = '0;
          state_d      = CONV;
        end
      end
      CONV: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(2 * SCK_HALF - 1)) begin
          cnt_d     = '0;
          ad_conv_d = 1'b0;
          state_d   = ADC_SHIFT;
        end
      end
      ADC_SHIFT: begin
        if (rise_tick) begin
          if (in_win(period, CH_A_FIRST, CH_A_LAST)) sh_a_d = {sh_a_q[CH_BITS-2:0], spi_miso};
          if (in_win(period, CH_B_FIRST, CH_B_LAST)) sh_b_d = {sh_b_q[CH_BITS-2:0], spi_miso};
        end
        if (fall_tick) begin
          bits_d = bits_q + 6'd1;
          if (bits_q == 6'(ADC_FRAME_BITS - 1)) begin
            bits_d  = '0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        datos_a_d = sh_a_q;
        datos_b_d = sh_b_q;
        ready_d   = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = INIT_WR;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= INIT_WR;
      cnt_q        <= '0;
      bits_q       <= '0;
      tick_q       <= '0;
      amp_sr_q     <= '0;
      gain_q       <= '0;
      gain_pend_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_pend_q <= 1'b0;
      overrun_q    <= 1'b0;
      sh_a_q       <= '0;
      sh_b_q       <= '0;
      datos_a_q    <= '0;
      datos_b_q    <= '0;
      ready_q      <= 1'b0;
      amp_cs_q     <= 1'b1;
      ad_conv_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bits_q       <= bits_d;
      tick_q       <= tick_d;
      amp_sr_q     <= amp_sr_d;
      gain_q       <= gain_d;
      gain_pend_q  <= gain_pend_d;
      busy_q       <= busy_d;
      frame_pend_q <= frame_pend_d;
      overrun_q    <= overrun_d;
      sh_a_q       <= sh_a_d;
      sh_b_q       <= sh_b_d;
      datos_a_q    <= datos_a_d;
      datos_b_q    <= datos_b_d;
      ready_q      <= ready_d;
      amp_cs_q     <= amp_cs_d;
      ad_conv_q    <= ad_conv_d;
    end
  end

  assign gain_busy = busy_q;
  assign datos_a   = datos_a_q;
  assign datos_b   = datos_b_q;
  assign ready     = ready_q;
  assign overrun   = overrun_q;
  assign spi_mosi  = amp_sr_q[AMP_BITS-1];
  assign amp_cs    = amp_cs_q;
  assign amp_shdn  = 1'b0;
  assign ad_conv   = ad_conv_q;

endmodule

// File: tb/tb_secuenciador_adc.sv
// Bench for secuenciador_adc: behavioural preamp and ADC models, one nominal-rate
// instance and one instance clocked with ticks faster than a frame.
module tb_secuenciador_adc;

  localparam int unsigned SCK_HALF   = 3;
  localparam logic [7:0]  GAIN_RESET = 8'h11;
  localparam int unsigned DIV0       = 1000;
  localparam int unsigned DIV1       = 100;
  localparam int unsigned GAIN_CLKS  = 18 * SCK_HALF;
  localparam int unsigned FRAME_LAT  = 2 * SCK_HALF * 35 + 1;

  logic        clock = 1'b0, reset_n = 1'b0, enable = 1'b0, gain_wr = 1'b0;
  logic [7:0]  gain_in = '0;
  logic        busy0, rdy0, ovr0, sck0, mosi0, cs0, shdn0, conv0, miso0 = 1'b0;
  logic        busy1, rdy1, ovr1, sck1, mosi1, cs1, shdn1, conv1, miso1 = 1'b0;
  logic [13:0] da0, db0, da1, db1;

  int unsigned n_cmp = 0, n_bad = 0;
  int unsigned cyc;

  always #5 clock = ~clock;

  secuenciador_adc #(.SCK_HALF(SCK_HALF), .SAMPLE_DIV(DIV0), .GAIN_RESET(GAIN_RESET)) dut0 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .gain_in(gain_in), .gain_wr(gain_wr),
    .gain_busy(busy0), .datos_a(da0), .datos_b(db0), .ready(rdy0), .overrun(ovr0),
    .spi_sck(sck0), .spi_mosi(mosi0), .spi_miso(miso0), .amp_cs(cs0), .amp_shdn(shdn0),
    .ad_conv(conv0));

  secuenciador_adc #(.SCK_HALF(SCK_HALF), .SAMPLE_DIV(DIV1), .GAIN_RESET(GAIN_RESET)) dut1 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .gain_in(gain_in), .gain_wr(1'b0),
    .gain_busy(busy1), .datos_a(da1), .datos_b(db1), .ready(rdy1), .overrun(ovr1),
    .spi_sck(sck1), .spi_mosi(mosi1), .spi_miso(miso1), .amp_cs(cs1), .amp_shdn(shdn1),
    .ad_conv(conv1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Clock edges since reset release; sample rate ticks land on multiples of SAMPLE_DIV.
  always @(posedge clock or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  // Preamp model (instance 0): shifts MOSI on SCK rise while selected.
  logic [7:0]  exp_gain[$];
  logic [7:0]  amp_sh, gwant;
  int unsigned amp_nb;
  always @(negedge cs0) begin amp_sh = '0; amp_nb = 0; end
  always @(posedge sck0) if (!cs0) begin amp_sh = {amp_sh[6:0], mosi0}; amp_nb++; end
  always @(posedge cs0) if (reset_n) begin
    check("amp_bits", amp_nb, 8);
    gwant = (exp_gain.size() > 0) ? exp_gain.pop_front() : 8'hxx;
    check("amp_gain", amp_sh, gwant);
  end

  // ADC models: a frame is {junk2, A, junk2, B, junk2}, bit for period p is presented
  // before that period's SCK rise and advanced on each SCK fall.
  logic [13:0] qa0[$], qb0[$], qa1[$], qb1[$];
  logic [13:0] a0, b0, a1, b1, ea, eb;
  logic [33:0] fr0, fr1;
  int unsigned per0, per1, nframe0 = 0, nrdy0 = 0, nrdy1 = 0;
  logic        act0 = 1'b0, act1 = 1'b0;

  always @(posedge conv0) if (reset_n) begin
    a0 = (nframe0 == 0) ? 14'h1ABC : 14'($urandom);
    b0 = (nframe0 == 0) ? 14'h2001 : 14'($urandom);
    nframe0++;
    fr0 = {2'($urandom), a0, 2'($urandom), b0, 2'($urandom)};
    qa0.push_back(a0); qb0.push_back(b0);
    per0 = 1; act0 = 1'b1; miso0 = fr0[33];
  end
  always @(negedge sck0) if (reset_n && act0) begin
    per0++;
    if (per0 <= 34) miso0 = fr0[34-per0];
    else            act0 = 1'b0;
  end

  always @(posedge conv1) if (reset_n) begin
    a1 = 14'($urandom); b1 = 14'($urandom);
    fr1 = {2'($urandom), a1, 2'($urandom), b1, 2'($urandom)};
    qa1.push_back(a1); qb1.push_back(b1);
    per1 = 1; act1 = 1'b1; miso1 = fr1[33];
  end
  always @(negedge sck1) if (reset_n && act1) begin
    per1++;
    if (per1 <= 34) miso1 = fr1[34-per1];
    else            act1 = 1'b0;
  end

  always @(negedge reset_n) begin
    act0 = 1'b0; act1 = 1'b0;
    qa0.delete(); qb0.delete(); qa1.delete(); qb1.delete();
    nrdy0 = 0; nrdy1 = 0;
  end

  // Edge timestamps and ready scoreboards, sampled away from the active edge.
  logic        cs0_p, conv0_p;
  int unsigned cs_rise_at, conv_at;
  always @(negedge clock) begin
    if (cs0 && !cs0_p)     cs_rise_at = cyc;
    if (conv0 && !conv0_p) conv_at = cyc;
    cs0_p = cs0; conv0_p = conv0;
    if (reset_n && rdy0) begin
      nrdy0++;
      ea = (qa0.size() > 0) ? qa0.pop_front() : 14'hxxxx;
      eb = (qb0.size() > 0) ? qb0.pop_front() : 14'hxxxx;
      check("datos_a", da0, ea);
      check("datos_b", db0, eb);
      check("frame_latency", cyc - conv_at, FRAME_LAT);
    end
    if (reset_n && rdy1) begin
      nrdy1++;
      ea = (qa1.size() > 0) ? qa1.pop_front() : 14'hxxxx;
      eb = (qb1.size() > 0) ? qb1.pop_front() : 14'hxxxx;
      check("fast_datos_a", da1, ea);
      check("fast_datos_b", db1, eb);
    end
  end

  task automatic wait_until(input int unsigned n);
    while (cyc < n) @(negedge clock);
  endtask

  task automatic pulse_gain(input logic [7:0] v, input logic expect_sent);
    gain_in = v;
    gain_wr = 1'b1;
    if (expect_sent) exp_gain.push_back(v);
    @(negedge clock);
    gain_wr = 1'b0;
  endtask

  task automatic do_release();
    exp_gain.push_back(GAIN_RESET);
    reset_n = 1'b1;
    @(negedge clock);
    check("init_cs_busy", {30'd0, cs0, busy0}, 32'b01);
    for (int i = 0; i < 200 && busy0; i++) @(negedge clock);
    check("init_busy_fall", cyc, 1 + GAIN_CLKS);
    check("init_cs_high", cs0, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst_ctrl", {sck0, mosi0, conv0, rdy0, ovr0, busy0, shdn0, cs0}, 8'b0000_0001);
    check("rst_data", {da0, db0}, '0);
    do_release();

    enable = 1'b1;
    wait_until(150);
    check("fast_ovr_first_tick", ovr1, 1'b0);
    wait_until(205);
    check("fast_ovr_second_tick", ovr1, 1'b1);

    // Gain request lands on the same edge as the 2nd tick.
    wait_until(2 * DIV0 - 1);
    check("frames_phase1", nrdy0, 1);
    pulse_gain(8'h34, 1'b1);
    wait_until(2 * DIV0 + 100);
    check("arb_conv_after_cs", conv_at - cs_rise_at, 1);
    check("arb_conv_at", conv_at, 2 * DIV0 + GAIN_CLKS + 2);
    check("arb_no_overrun", ovr0, 1'b0);

    wait_until(2400);
    pulse_gain(8'h5A, 1'b1);
    repeat (9) @(negedge clock);
    check("busy_during_write", busy0, 1'b1);
    pulse_gain(8'hC3, 1'b0);
    wait_until(2600);
    check("busy_cleared", busy0, 1'b0);

    // Reset in the middle of the ADC shift of the 3rd frame.
    wait_until(3100 + $urandom_range(0, 5));
    #2 reset_n = 1'b0;
    #1;
    check("midrst_ctrl", {sck0, conv0, rdy0, cs0, ovr1}, 5'b00010);
    check("midrst_data", {da0, db0}, '0);
    @(negedge clock);
    do_release();

    enable = 1'b0;
    wait_until(1500);
    check("no_frames_disabled", nrdy0, 0);
    enable = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      wait_until(k * DIV0 - 600 + $urandom_range(0, 400));
      pulse_gain(8'($urandom), 1'b1);
    end
    wait_until(5300);
    check("frames_phase2", nrdy0, 4);
    check("fast_frames_phase2", nrdy1, 12);
    check("ovr_nominal", ovr0, 1'b0);
    check("ovr_fast", ovr1, 1'b1);
    check("gains_outstanding", exp_gain.size(), 0);
    check("frames_outstanding", qa0.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, want finish before 1 ms");
    $fatal(1, "watchdog");
  end

endmodule
